// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC engine: FSM encoding, bit reversal
// and the legal-parameter check used at elaboration.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        DONE    = 2'd2,
        PROCESS = 2'd3
    } crc_state_e;

    localparam int BYTE_BITS = 8;

    // Reverses the low `width` bits of v; bits at and above `width` return zero.
    function automatic logic [31:0] reverse_bits(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = v[width-1-i];
            end
        end
        return r;
    endfunction

    function automatic bit params_legal(input int crc_width, input int bits_per_cycle);
        bit width_ok;
        bit bpc_ok;
        width_ok = (crc_width >= 8) && (crc_width <= 32);
        bpc_ok   = (bits_per_cycle == 1) || (bits_per_cycle == 2) ||
                   (bits_per_cycle == 4) || (bits_per_cycle == 8);
        return width_ok && bpc_ok;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational fold of BITS_PER_CYCLE message bits into the CRC register,
// most significant input bit first, using the direct (non-augmented) rule.
module crc_step #(
    parameter int                   CRC_WIDTH      = 8,
    parameter logic [CRC_WIDTH-1:0] POLY           = 8'h07,
    parameter int                   BITS_PER_CYCLE = 1
) (
    input  logic [CRC_WIDTH-1:0]      crc_in,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    output logic [CRC_WIDTH-1:0]      crc_out
);

    logic [CRC_WIDTH-1:0] acc;
    logic                 fb;

    always_comb begin
        acc = crc_in;
        fb  = 1'b0;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            fb  = acc[CRC_WIDTH-1] ^ bits[i];
            acc = (acc << 1) ^ (fb ? POLY : '0);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed byte-stream CRC engine: accepts one byte per ACCEPT visit, folds it
// over 8/BITS_PER_CYCLE PROCESS cycles and presents a held result in DONE.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int                   CRC_WIDTH      = 8,
    parameter logic [CRC_WIDTH-1:0] POLY           = 8'h07,
    parameter logic [CRC_WIDTH-1:0] INIT           = '0,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT        = '0,
    parameter bit                   REFLECT_IN     = 1'b0,
    parameter bit                   REFLECT_OUT    = 1'b0,
    parameter int                   BITS_PER_CYCLE = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    input  logic                 data_last,
    output logic                 data_ready,
    output logic [CRC_WIDTH-1:0] crc,
    output logic                 crc_valid,
    output logic                 busy,
    output crc_state_e           state
);

    if (!params_legal(CRC_WIDTH, BITS_PER_CYCLE)) begin : g_param_check
        $error("crc_stream_engine: CRC_WIDTH must be 8..32 and BITS_PER_CYCLE 1, 2, 4 or 8");
    end

    localparam int         STEPS      = BYTE_BITS / BITS_PER_CYCLE;
    localparam logic [2:0] LAST_COUNT = 3'(STEPS - 1);

    // Handshake: a byte is consumed on a rising edge where data_valid and
    // data_ready are both high; data_ready depends only on the current state.
    crc_state_e           next_state;
    logic [CRC_WIDTH-1:0] crc_reg;
    logic [CRC_WIDTH-1:0] step_out;
    logic [CRC_WIDTH-1:0] final_value;
    logic [7:0]           shift_byte;
    logic [7:0]           captured_byte;
    logic                 last_flag;
    logic [2:0]           count;
    logic                 fold_done;

    crc_step #(
        .CRC_WIDTH      (CRC_WIDTH),
        .POLY           (POLY),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .crc_in  (crc_reg),
        .bits    (shift_byte[7 -: BITS_PER_CYCLE]),
        .crc_out (step_out)
    );

    always_comb begin
        captured_byte = REFLECT_IN ? 8'(reverse_bits(32'(data_in), BYTE_BITS)) : data_in;
        final_value   = (REFLECT_OUT ? CRC_WIDTH'(reverse_bits(32'(step_out), CRC_WIDTH))
                                     : step_out) ^ XOR_OUT;
        fold_done     = (count == LAST_COUNT);
    end

    always_comb begin
        next_state = state;
        data_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = ACCEPT;
            end
            ACCEPT: begin
                data_ready = 1'b1;
                busy       = 1'b1;
                if (start)           next_state = ACCEPT;
                else if (data_valid) next_state = PROCESS;
            end
            PROCESS: begin
                busy = 1'b1;
                if (start)          next_state = ACCEPT;
                else if (fold_done) next_state = last_flag ? DONE : ACCEPT;
            end
            DONE: begin
                if (start) next_state = ACCEPT;
            end
            default: next_state = IDLE;
        endcase
    end

    // A start in any state restarts the frame and discards partial work.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            crc_reg    <= INIT;
            shift_byte <= '0;
            last_flag  <= 1'b0;
            count      <= '0;
            crc        <= '0;
            crc_valid  <= 1'b0;
        end else begin
            state <= next_state;
            if (start) begin
                crc_reg   <= INIT;
                crc_valid <= 1'b0;
                count     <= '0;
            end else begin
                case (state)
                    ACCEPT: begin
                        if (data_valid) begin
                            shift_byte <= captured_byte;
                            last_flag  <= data_last;
                            count      <= '0;
                        end
                    end
                    PROCESS: begin
                        crc_reg    <= step_out;
                        shift_byte <= shift_byte << BITS_PER_CYCLE;
                        count      <= count + 3'd1;
                        if (fold_done && last_flag) begin
                            crc       <= final_value;
                            crc_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine: three parameter sets, scoreboard of
// expected CRCs from a software model, plus handshake and timing checks.
module tb_crc_stream_engine;
    import crc_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;

    logic       start_s [3];
    logic [7:0] data_s  [3];
    logic       valid_s [3];
    logic       last_s  [3];
    logic       ready_s [3];
    logic       cvalid_s[3];
    logic       busy_s  [3];
    crc_state_e state_s [3];

    logic [7:0]  crc8;
    logic [15:0] crc16;
    logic [31:0] crc32;

    int          cfg_w   [3] = '{8, 16, 32};
    logic [31:0] cfg_poly[3] = '{32'h07, 32'h1021, 32'h04C11DB7};
    logic [31:0] cfg_init[3] = '{32'h0, 32'hFFFF, 32'hFFFFFFFF};
    logic [31:0] cfg_xor [3] = '{32'h0, 32'h0, 32'hFFFFFFFF};
    bit          cfg_rin [3] = '{1'b0, 1'b0, 1'b1};
    bit          cfg_rout[3] = '{1'b0, 1'b0, 1'b1};

    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    crc_stream_engine u_crc8 (
        .clock(clock), .reset(reset), .start(start_s[0]), .data_in(data_s[0]),
        .data_valid(valid_s[0]), .data_last(last_s[0]), .data_ready(ready_s[0]),
        .crc(crc8), .crc_valid(cvalid_s[0]), .busy(busy_s[0]), .state(state_s[0])
    );

    crc_stream_engine #(
        .CRC_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF), .BITS_PER_CYCLE(8)
    ) u_crc16 (
        .clock(clock), .reset(reset), .start(start_s[1]), .data_in(data_s[1]),
        .data_valid(valid_s[1]), .data_last(last_s[1]), .data_ready(ready_s[1]),
        .crc(crc16), .crc_valid(cvalid_s[1]), .busy(busy_s[1]), .state(state_s[1])
    );

    crc_stream_engine #(
        .CRC_WIDTH(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
        .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .BITS_PER_CYCLE(4)
    ) u_crc32 (
        .clock(clock), .reset(reset), .start(start_s[2]), .data_in(data_s[2]),
        .data_valid(valid_s[2]), .data_last(last_s[2]), .data_ready(ready_s[2]),
        .crc(crc32), .crc_valid(cvalid_s[2]), .busy(busy_s[2]), .state(state_s[2])
    );

    function automatic logic [31:0] get_crc(input int d);
        case (d)
            0:       return 32'(crc8);
            1:       return 32'(crc16);
            default: return crc32;
        endcase
    endfunction

    function automatic logic [31:0] model_crc(input int d, input logic [7:0] bytes[$]);
        logic [31:0] mask, top, r, rr;
        logic [7:0]  b;
        int          w;
        w    = cfg_w[d];
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        top  = 32'd1 << (w - 1);
        r    = cfg_init[d];
        foreach (bytes[i]) begin
            b = bytes[i];
            if (cfg_rin[d]) b = {<<{b}};
            r = r ^ (32'(b) << (w - 8));
            for (int j = 0; j < 8; j++) begin
                if ((r & top) != 0) r = ((r << 1) ^ cfg_poly[d]) & mask;
                else                r = (r << 1) & mask;
            end
        end
        if (cfg_rout[d]) begin
            rr = '0;
            for (int i = 0; i < w; i++) rr[i] = r[w-1-i];
            r = rr;
        end
        return r ^ cfg_xor[d];
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_start(input int d);
        start_s[d] = 1'b1;
        @(negedge clock);
        start_s[d] = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is consumed.
    task automatic send_byte(input int d, input logic [7:0] b, input logic l, output int acc_cycle);
        int n;
        n = 0;
        data_s[d]  = b;
        valid_s[d] = 1'b1;
        last_s[d]  = l;
        while (!ready_s[d] && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("ready_timeout", 32'(n < 100), 32'd1);
        acc_cycle = cycle;
        @(negedge clock);
        valid_s[d] = 1'b0;
        last_s[d]  = 1'b0;
    endtask

    task automatic send_frame(input int d, input logic [7:0] bytes[$], input int interval,
                              output int last_acc);
        int acc, prev;
        prev = -1;
        exp_q.push_back(model_crc(d, bytes));
        foreach (bytes[i]) begin
            send_byte(d, bytes[i], i == bytes.size() - 1, acc);
            if (interval > 0 && prev >= 0) check("byte_interval", 32'(acc - prev), 32'(interval));
            prev = acc;
        end
        last_acc = prev;
    endtask

    task automatic wait_result(input int d, output int seen_cycle);
        int n;
        logic [31:0] exp;
        n = 0;
        while (!cvalid_s[d] && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("crc_valid_timeout", 32'(n < 200), 32'd1);
        seen_cycle = cycle;
        exp = exp_q.pop_front();
        check("scoreboard_crc", get_crc(d), exp);
    endtask

    task automatic bp_frame(input int d, input int nbytes);
        logic [7:0] got[$];
        int n, k, seen;
        n = 0;
        k = 0;
        do_start(d);
        valid_s[d] = 1'b1;
        while (k < nbytes && n < 400) begin
            data_s[d] = 8'($urandom_range(0, 255));
            last_s[d] = (k == nbytes - 1);
            if (ready_s[d]) begin
                got.push_back(data_s[d]);
                k++;
            end
            @(negedge clock);
            n++;
        end
        valid_s[d] = 1'b0;
        last_s[d]  = 1'b0;
        check("bp_bytes_consumed", 32'(k), 32'(nbytes));
        exp_q.push_back(model_crc(d, got));
        wait_result(d, seen);
    endtask

    initial begin
        logic [7:0] msg[$];
        logic [7:0] one[$];
        logic [7:0] zero[$];
        logic [7:0] two[$];
        int acc, seen;
        msg  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        one  = '{8'h01};
        zero = '{8'h00};
        two  = '{8'hA5, 8'h3C};
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            data_s[d]  = 8'h00;
            valid_s[d] = 1'b0;
            last_s[d]  = 1'b0;
        end

        // Reset state, checked while reset is still asserted.
        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            check("reset_state", 32'(state_s[d]), 32'(IDLE));
            check("reset_crc", get_crc(d), 32'h0);
            check("reset_crc_valid", 32'(cvalid_s[d]), 32'd0);
            check("reset_ready", 32'(ready_s[d]), 32'd0);
            check("reset_busy", 32'(busy_s[d]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        // CRC-8, BPC=1, with a stray data_last before the first byte.
        do_start(0);
        check("start_to_ready", 32'(ready_s[0]), 32'd1);
        check("start_busy", 32'(busy_s[0]), 32'd1);
        last_s[0] = 1'b1;
        repeat (3) @(negedge clock);
        last_s[0] = 1'b0;
        check("last_without_valid", 32'(state_s[0]), 32'(ACCEPT));
        send_frame(0, msg, 9, acc);
        wait_result(0, seen);
        check("crc8_check_value", get_crc(0), 32'hF4);
        check("done_busy", 32'(busy_s[0]), 32'd0);

        // CRC-16/CCITT-FALSE, BPC=8.
        do_start(1);
        send_frame(1, msg, 2, acc);
        wait_result(1, seen);
        check("crc16_latency", 32'(seen - acc), 32'd2);
        check("crc16_check_value", get_crc(1), 32'h29B1);

        // CRC-32, reflected, BPC=4.
        do_start(2);
        send_frame(2, msg, 3, acc);
        wait_result(2, seen);
        check("crc32_check_value", get_crc(2), 32'hCBF43926);

        // Single bytes, result hold and crc_valid drop on start.
        do_start(0);
        send_frame(0, one, 0, acc);
        wait_result(0, seen);
        check("crc8_byte01", get_crc(0), 32'h07);
        valid_s[0] = 1'b1;
        data_s[0]  = 8'hFF;
        repeat (5) @(negedge clock);
        valid_s[0] = 1'b0;
        check("hold_crc_valid", 32'(cvalid_s[0]), 32'd1);
        check("hold_crc", get_crc(0), 32'h07);
        do_start(0);
        check("start_clears_valid", 32'(cvalid_s[0]), 32'd0);
        send_frame(0, zero, 0, acc);
        wait_result(0, seen);
        check("crc8_byte00", get_crc(0), 32'h00);

        // Abort mid-frame, then a full frame.
        do_start(0);
        send_byte(0, two[0], 1'b0, acc);
        repeat (8) @(negedge clock);
        send_byte(0, two[1], 1'b0, acc);
        check("abort_in_process", 32'(state_s[0]), 32'(PROCESS));
        do_start(0);
        check("abort_to_accept", 32'(state_s[0]), 32'(ACCEPT));
        send_frame(0, msg, 9, acc);
        wait_result(0, seen);
        check("abort_crc8", get_crc(0), 32'hF4);

        // Reset during PROCESS.
        do_start(0);
        send_byte(0, 8'h5A, 1'b1, acc);
        check("pre_reset_state", 32'(state_s[0]), 32'(PROCESS));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_state", 32'(state_s[0]), 32'(IDLE));
        check("midreset_crc_valid", 32'(cvalid_s[0]), 32'd0);
        check("midreset_ready", 32'(ready_s[0]), 32'd0);
        repeat (10) @(negedge clock);
        check("midreset_stays_idle", 32'(state_s[0]), 32'(IDLE));

        // Backpressure: data_valid held high with bytes changing every cycle.
        bp_frame(0, 5);
        bp_frame(1, 6);
        bp_frame(2, 4);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
